// File: rtl/sens_ultra_axil_slave.sv
// AXI4-Lite controlled ultrasonic range sensor: trigger pulse, echo width measurement, timeout.
// Optional macro SENS_ULTRA_IRQ_EN adds the IRQ output and the CTRL.IRQ_EN bit.
module sens_ultra_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
`ifdef SENS_ULTRA_IRQ_EN
  output logic                            IRQ,
`endif
  output logic                            TRIG,
  input  logic                            ECHO
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [DW-1:0] CNT_SAT = {{(DW-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t        state;
  logic          axi_awready;
  logic          axi_arready;
  logic          ctrl_start;
  logic          ctrl_cont;
  logic          irq_en_rd;
  logic [DW-1:0] trig_len;
  logic [DW-1:0] timeout;
  logic [DW-1:0] scratch;
  logic          status_valid;
  logic          status_err;
  logic [DW-1:0] echo_cnt;
  logic [DW-1:0] trig_cnt;
  logic [DW-1:0] tmo_cnt;
  logic [DW-1:0] meas_cnt;
  logic          tmo_hit;
  logic          echo_s1, echo_s2, echo_s3;
  logic          trig_q;
  logic          busy;
  logic          wr_hs, rd_hs, status_rd;
  logic [2:0]    wr_idx, rd_idx;
  logic [DW-1:0] rd_word;
  logic          unused;

  assign wr_idx    = S_AXI_AWADDR[4:2];
  assign rd_idx    = S_AXI_ARADDR[4:2];
  assign wr_hs     = axi_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs     = axi_arready & S_AXI_ARVALID;
  assign status_rd = rd_hs && (rd_idx == 3'd4);
  assign busy      = (state == S_TRIG) || (state == S_WAIT_RISE) || (state == S_MEASURE);

  assign S_AXI_AWREADY = axi_awready;
  assign S_AXI_WREADY  = axi_awready;
  assign S_AXI_ARREADY = axi_arready;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign TRIG          = trig_q;
  assign unused        = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int unsigned i = 0; i < DW/8; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

`ifdef SENS_ULTRA_IRQ_EN
  logic ctrl_irq_en;
  assign irq_en_rd = ctrl_irq_en;
  assign IRQ       = status_valid & ctrl_irq_en;
`else
  assign irq_en_rd = 1'b0;
`endif

  // Write channel and R/W registers; START is a one-cycle strobe.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      axi_awready  <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      ctrl_start   <= 1'b0;
      ctrl_cont    <= 1'b0;
      trig_len     <= DW'(1000);
      timeout      <= DW'(2500000);
      scratch      <= '0;
`ifdef SENS_ULTRA_IRQ_EN
      ctrl_irq_en  <= 1'b0;
`endif
    end else begin
      axi_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~axi_awready;
      ctrl_start  <= 1'b0;
      if (wr_hs) begin
        S_AXI_BVALID <= 1'b1;
        case (wr_idx)
          3'd0: if (S_AXI_WSTRB[0]) begin
            ctrl_start  <= S_AXI_WDATA[0];
            ctrl_cont   <= S_AXI_WDATA[1];
`ifdef SENS_ULTRA_IRQ_EN
            ctrl_irq_en <= S_AXI_WDATA[2];
`endif
          end
          3'd1:    trig_len <= apply_strb(trig_len, S_AXI_WDATA, S_AXI_WSTRB);
          3'd2:    timeout  <= apply_strb(timeout, S_AXI_WDATA, S_AXI_WSTRB);
          3'd3:    scratch  <= apply_strb(scratch, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      3'd0:    rd_word[2:0] = {irq_en_rd, ctrl_cont, ctrl_start};
      3'd1:    rd_word = trig_len;
      3'd2:    rd_word = timeout;
      3'd3:    rd_word = scratch;
      3'd4:    rd_word[2:0] = {status_err, status_valid, busy};
      3'd5:    rd_word = echo_cnt;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      axi_arready  <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
    end else begin
      axi_arready <= S_AXI_ARVALID & ~S_AXI_RVALID & ~axi_arready;
      if (rd_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Measurement FSM; DONE's flag update is placed after the STATUS-read clear so it wins.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= S_IDLE;
      trig_q       <= 1'b0;
      trig_cnt     <= '0;
      tmo_cnt      <= '0;
      meas_cnt     <= '0;
      tmo_hit      <= 1'b0;
      status_valid <= 1'b0;
      status_err   <= 1'b0;
      echo_cnt     <= '0;
      echo_s1      <= 1'b0;
      echo_s2      <= 1'b0;
      echo_s3      <= 1'b0;
    end else begin
      echo_s1 <= ECHO;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
      if (status_rd) begin
        status_valid <= 1'b0;
        status_err   <= 1'b0;
      end
      case (state)
        S_IDLE: if (ctrl_start || ctrl_cont) begin
          state        <= S_TRIG;
          trig_q       <= 1'b1;
          trig_cnt     <= (trig_len == '0) ? '0 : trig_len - 1'b1;
          tmo_hit      <= 1'b0;
          status_valid <= 1'b0;
          status_err   <= 1'b0;
        end
        S_TRIG: begin
          if (trig_cnt == '0) begin
            trig_q   <= 1'b0;
            state    <= S_WAIT_RISE;
            tmo_cnt  <= timeout;
            meas_cnt <= '0;
          end else begin
            trig_cnt <= trig_cnt - 1'b1;
          end
        end
        S_WAIT_RISE: begin
          if (tmo_cnt == '0) begin
            tmo_hit <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
            if (echo_s2 && !echo_s3) begin
              meas_cnt <= DW'(1);
              state    <= S_MEASURE;
            end
          end
        end
        S_MEASURE: begin
          if (tmo_cnt == '0) begin
            tmo_hit <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
            if (echo_s2) begin
              if (meas_cnt != CNT_SAT) meas_cnt <= meas_cnt + 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          echo_cnt     <= tmo_hit ? '1 : meas_cnt;
          status_valid <= 1'b1;
          status_err   <= tmo_hit;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
